// File: rtl/rob_pkg.sv
// Shared defaults, derived widths and the {row,col} unique-ID layout used by
// the AR ID allocator and anything that needs to build or decode its uids.
package rob_pkg;

  localparam int DEF_ID_WIDTH  = 4;
  localparam int DEF_NUM_ROWS  = 16;
  localparam int DEF_NUM_COLS  = 16;
  localparam int DEF_ROW_W     = $clog2(DEF_NUM_ROWS);
  localparam int DEF_COL_W     = $clog2(DEF_NUM_COLS);
  localparam int DEF_UID_WIDTH = DEF_ROW_W + DEF_COL_W;

  typedef struct packed {
    logic [DEF_ROW_W-1:0] row;
    logic [DEF_COL_W-1:0] col;
  } uid_t;

  function automatic uid_t make_uid(input int row, input int col);
    uid_t u;
    u.row = DEF_ROW_W'(row);
    u.col = DEF_COL_W'(col);
    return u;
  endfunction

endpackage

// File: rtl/ar_id_allocator_prio_enc.sv
// First-one encoder: picks the lowest set request bit, reporting it both
// one-hot and as a binary index, plus whether any request was set.
module prio_enc #(
  parameter  int N = 16,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_onehot,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  always_comb begin
    logic w_seen;
    w_seen   = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i] && !w_seen) begin
        o_onehot[i] = 1'b1;
        o_idx       = W'(i);
        w_seen      = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/ar_id_allocator.sv
// Maps original AXI read IDs onto unique {row,col} IDs: each in-use row is bound
// to one original ID and hands out columns in order; responses free in order.
module ar_id_allocator
  import rob_pkg::*;
#(
  parameter  int ID_WIDTH  = DEF_ID_WIDTH,
  parameter  int NUM_ROWS  = DEF_NUM_ROWS,
  parameter  int NUM_COLS  = DEF_NUM_COLS,
  localparam int ROW_W     = $clog2(NUM_ROWS),
  localparam int COL_W     = $clog2(NUM_COLS),
  localparam int UID_WIDTH = ROW_W + COL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [ID_WIDTH-1:0]  alloc_orig_id,
  output logic                 alloc_ready,
  output logic [UID_WIDTH-1:0] alloc_uid,
  input  logic                 free_req,
  input  logic [UID_WIDTH-1:0] uid_to_restore,
  output logic [ID_WIDTH-1:0]  restored_id,
  output logic                 free_err,
  output logic [ROW_W:0]       rows_in_use
);

  logic [NUM_ROWS-1:0] r_row_valid;
  logic [ID_WIDTH-1:0] r_row_orig_id [NUM_ROWS];
  logic [COL_W-1:0]    r_alloc_idx   [NUM_ROWS];
  logic [COL_W:0]      r_out_cnt     [NUM_ROWS];
  logic [ROW_W:0]      r_rows_in_use;
  logic                r_free_err;

  logic [NUM_ROWS-1:0] w_valid_nxt;
  logic [ID_WIDTH-1:0] w_id_nxt  [NUM_ROWS];
  logic [COL_W-1:0]    w_idx_nxt [NUM_ROWS];
  logic [COL_W:0]      w_cnt_nxt [NUM_ROWS];

  logic [NUM_ROWS-1:0] w_match_vec;
  logic [NUM_ROWS-1:0] w_empty_vec;
  logic [NUM_ROWS-1:0] w_full_vec;
  logic [NUM_ROWS-1:0] w_match_oh;
  logic [NUM_ROWS-1:0] w_free_oh;
  logic [NUM_ROWS-1:0] w_tgt_oh;
  logic [NUM_ROWS-1:0] w_grant_row;
  logic [NUM_ROWS-1:0] w_free_hit;
  logic [ROW_W-1:0]    w_match_idx;
  logic [ROW_W-1:0]    w_free_idx;
  logic [ROW_W-1:0]    w_tgt_row;
  logic [ROW_W-1:0]    w_free_row;
  logic                w_match_any;
  logic                w_free_any;
  logic                w_grant;
  logic                w_free_ok;
  logic                w_free_bad;
  logic [ROW_W:0]      w_pop;
  logic                w_unused_col;

  // Frees are strictly in order per row, so the column part only rides along.
  assign w_free_row   = uid_to_restore[UID_WIDTH-1:COL_W];
  assign w_unused_col = ^uid_to_restore[COL_W-1:0];

  generate
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign w_match_vec[gi] = r_row_valid[gi] && (r_row_orig_id[gi] == alloc_orig_id);
      assign w_empty_vec[gi] = ~r_row_valid[gi];
      assign w_full_vec[gi]  = (r_out_cnt[gi] >= (COL_W+1)'(NUM_COLS));
      assign w_grant_row[gi] = w_grant & w_tgt_oh[gi];
      assign w_free_hit[gi]  = w_free_ok && (w_free_row == ROW_W'(gi));

      // A grant and a free landing on the same row cancel in the count and keep it bound.
      assign w_valid_nxt[gi] = w_grant_row[gi] |
                               (r_row_valid[gi] &
                                ~(w_free_hit[gi] && (r_out_cnt[gi] == (COL_W+1)'(1))));
      assign w_id_nxt[gi]    = w_grant_row[gi] ? alloc_orig_id : r_row_orig_id[gi];
      assign w_idx_nxt[gi]   = !w_grant_row[gi] ? r_alloc_idx[gi] :
                               (r_alloc_idx[gi] == COL_W'(NUM_COLS - 1)) ? '0 :
                               r_alloc_idx[gi] + COL_W'(1);
      assign w_cnt_nxt[gi]   = (w_grant_row[gi] && !w_free_hit[gi]) ? r_out_cnt[gi] + (COL_W+1)'(1) :
                               (!w_grant_row[gi] && w_free_hit[gi]) ? r_out_cnt[gi] - (COL_W+1)'(1) :
                               r_out_cnt[gi];
    end
  endgenerate

  prio_enc #(.N(NUM_ROWS)) u_match_enc (
    .i_req    (w_match_vec),
    .o_onehot (w_match_oh),
    .o_idx    (w_match_idx),
    .o_valid  (w_match_any)
  );

  prio_enc #(.N(NUM_ROWS)) u_free_enc (
    .i_req    (w_empty_vec),
    .o_onehot (w_free_oh),
    .o_idx    (w_free_idx),
    .o_valid  (w_free_any)
  );

  // Lookup uses pre-update state, so a row emptied this cycle is not a candidate yet.
  assign w_tgt_oh    = w_match_any ? w_match_oh  : w_free_oh;
  assign w_tgt_row   = w_match_any ? w_match_idx : w_free_idx;
  assign alloc_ready = w_match_any ? ~|(w_match_oh & w_full_vec) : w_free_any;
  assign alloc_uid   = {w_tgt_row, r_alloc_idx[w_tgt_row]};
  assign w_grant     = alloc_valid & alloc_ready;

  assign w_free_ok   = free_req && (r_out_cnt[w_free_row] != '0);
  assign w_free_bad  = free_req && (r_out_cnt[w_free_row] == '0);
  assign restored_id = r_row_orig_id[w_free_row];

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      w_pop = w_pop + {{ROW_W{1'b0}}, w_valid_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_valid   <= '0;
      r_rows_in_use <= '0;
      r_free_err    <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        r_row_orig_id[i] <= '0;
        r_alloc_idx[i]   <= '0;
        r_out_cnt[i]     <= '0;
      end
    end else begin
      r_row_valid   <= w_valid_nxt;
      r_rows_in_use <= w_pop;
      r_free_err    <= w_free_bad;
      for (int i = 0; i < NUM_ROWS; i++) begin
        r_row_orig_id[i] <= w_id_nxt[i];
        r_alloc_idx[i]   <= w_idx_nxt[i];
        r_out_cnt[i]     <= w_cnt_nxt[i];
      end
    end
  end

  assign free_err    = r_free_err;
  assign rows_in_use = r_rows_in_use;

endmodule

// File: tb/tb_ar_id_allocator.sv
// Self-checking bench for ar_id_allocator: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based row model.
module tb_ar_id_allocator;
  import rob_pkg::*;

  localparam int IDW = 5;
  localparam int NR  = 16;
  localparam int NC  = 16;
  localparam int RW  = 4;
  localparam int UW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [IDW-1:0] alloc_orig_id;
  logic          alloc_ready;
  logic [UW-1:0] alloc_uid;
  logic          free_req;
  logic [UW-1:0] uid_to_restore;
  logic [IDW-1:0] restored_id;
  logic          free_err;
  logic [RW:0]   rows_in_use;

  ar_id_allocator #(.ID_WIDTH(IDW), .NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_orig_id  (alloc_orig_id),
    .alloc_ready    (alloc_ready),
    .alloc_uid      (alloc_uid),
    .free_req       (free_req),
    .uid_to_restore (uid_to_restore),
    .restored_id    (restored_id),
    .free_err       (free_err),
    .rows_in_use    (rows_in_use)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: each row is a FIFO of outstanding columns; a row is in use while non-empty.
  int unsigned m_q [NR][$];
  int          m_bound [NR];
  int          m_next  [NR];

  typedef struct {
    bit r;
    bit av;
    int id;
    bit fr;
    int u;
    int e_ready;
    int e_uid;
    int e_rest;
    int e_ferr;
    int e_rows;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mkv(int r, int av, int id, int fr, int u,
                               int er, int eu, int erest, int ef, int erows);
    vec_t v;
    v.r = (r != 0); v.av = (av != 0); v.id = id; v.fr = (fr != 0); v.u = u;
    v.e_ready = er; v.e_uid = eu; v.e_rest = erest; v.e_ferr = ef; v.e_rows = erows;
    return v;
  endfunction

  function automatic int m_match(int id);
    for (int r = 0; r < NR; r++) if (m_q[r].size() > 0 && m_bound[r] == id) return r;
    return -1;
  endfunction

  function automatic int m_lowest_free();
    for (int r = 0; r < NR; r++) if (m_q[r].size() == 0) return r;
    return -1;
  endfunction

  function automatic int m_rows();
    int c = 0;
    for (int r = 0; r < NR; r++) if (m_q[r].size() > 0) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NR; r++) begin
      m_q[r].delete();
      m_bound[r] = 0;
      m_next[r]  = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // One clock: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit r, input bit av, input int id, input bit fr, input int u,
                      output int o_ready, output int o_uid, output int o_rest,
                      output int o_ferr, output int o_rows);
    int mr, mf, tgt, e_ready, e_uid, e_rest, e_ferr, frow;
    rst = r; alloc_valid = av; alloc_orig_id = IDW'(id);
    free_req = fr; uid_to_restore = UW'(u);
    #1;
    mr      = m_match(id);
    mf      = m_lowest_free();
    tgt     = (mr >= 0) ? mr : mf;
    e_ready = (mr >= 0) ? int'(m_q[mr].size() < NC) : int'(mf >= 0);
    e_uid   = (tgt >= 0) ? tgt * NC + m_next[tgt] : 0;
    frow    = u / NC;
    e_rest  = m_bound[frow];
    o_ready = int'(alloc_ready);
    o_uid   = int'(alloc_uid);
    o_rest  = int'(restored_id);
    chk("model_ready", o_ready, e_ready);
    if (e_ready != 0) chk("model_uid", o_uid, e_uid);
    chk("model_restored", o_rest, e_rest);
    e_ferr = 0;
    if (r) begin
      m_reset();
    end else begin
      e_ferr = int'(fr && m_q[frow].size() == 0);
      if (fr && e_ferr == 0) void'(m_q[frow].pop_front());
      if (av && e_ready != 0) begin
        m_q[tgt].push_back(m_next[tgt]);
        m_bound[tgt] = id;
        m_next[tgt]  = (m_next[tgt] + 1) % NC;
      end
    end
    @(posedge clk);
    @(negedge clk);
    o_ferr = int'(free_err);
    o_rows = int'(rows_in_use);
    chk("model_free_err", o_ferr, e_ferr);
    chk("model_rows_in_use", o_rows, m_rows());
    $display("cyc rst=%0d av=%0d id=%0d fr=%0d u=%02h -> ready=%0d uid=%02h rest=%0d ferr=%0d rows=%0d",
             r, av, id, fr, u, o_ready, o_uid, o_rest, o_ferr, o_rows);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_ready, a_uid, a_rest, a_ferr, a_rows;
    int row, col, st;
    bit rr, av, fr;
    uid_t uu;

    rst = 1'b1; alloc_valid = 1'b0; alloc_orig_id = '0; free_req = 1'b0; uid_to_restore = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();
    rst = 1'b0;
    #1;
    chk("reset_ready", int'(alloc_ready), 1);
    chk("reset_uid", int'(alloc_uid), 0);
    chk("reset_restored", int'(restored_id), 0);
    chk("reset_rows", int'(rows_in_use), 0);
    chk("reset_free_err", int'(free_err), 0);

    tbl[0]  = mkv(0, 1, 3, 0, 'h00, 1, 'h00, 0, 0, 1);
    tbl[1]  = mkv(0, 1, 3, 0, 'h01, 1, 'h01, 3, 0, 1);
    tbl[2]  = mkv(0, 1, 3, 0, 'h01, 1, 'h02, 3, 0, 1);
    tbl[3]  = mkv(0, 0, 3, 0, 'h01, 1, 'h03, 3, 0, 1);
    tbl[4]  = mkv(0, 0, 3, 1, 'h00, 1, 'h03, 3, 0, 1);
    tbl[5]  = mkv(0, 0, 3, 1, 'h01, 1, 'h03, 3, 0, 1);
    tbl[6]  = mkv(0, 0, 3, 1, 'h02, 1, 'h03, 3, 0, 0);
    tbl[7]  = mkv(1, 1, 3, 0, 'h00, 1, 'h03, 3, 0, 0);
    tbl[8]  = mkv(0, 1, 3, 0, 'h00, 1, 'h00, 0, 0, 1);
    tbl[9]  = mkv(0, 1, 7, 0, 'h00, 1, 'h10, 3, 0, 2);
    tbl[10] = mkv(0, 0, 9, 1, 'h00, 1, 'h20, 3, 0, 1);
    tbl[11] = mkv(0, 1, 9, 0, 'h10, 1, 'h01, 7, 0, 2);
    tbl[12] = mkv(0, 0, 9, 1, 'h30, 1, 'h02, 0, 1, 2);
    tbl[13] = mkv(0, 0, 9, 0, 'h10, 1, 'h02, 7, 0, 2);

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].av, tbl[i].id, tbl[i].fr, tbl[i].u,
           a_ready, a_uid, a_rest, a_ferr, a_rows);
      chk($sformatf("tbl%0d_ready", i), a_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_uid", i), a_uid, tbl[i].e_uid);
      chk($sformatf("tbl%0d_restored", i), a_rest, tbl[i].e_rest);
      chk($sformatf("tbl%0d_free_err", i), a_ferr, tbl[i].e_ferr);
      chk($sformatf("tbl%0d_rows", i), a_rows, tbl[i].e_rows);
    end

    // Fill one row's columns, hit the full limit, free one and wrap to column 0.
    step(1, 0, 0, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
    for (int i = 0; i < NC; i++) begin
      step(0, 1, 5, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
      chk($sformatf("full_uid%0d", i), a_uid, i);
    end
    step(0, 1, 5, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
    chk("full_ready_low", a_ready, 0);
    chk("full_rows", a_rows, 1);
    step(0, 0, 5, 1, 'h00, a_ready, a_uid, a_rest, a_ferr, a_rows);
    step(0, 1, 5, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
    chk("wrap_ready", a_ready, 1);
    chk("wrap_uid", a_uid, 'h00);

    // Bind every row to a distinct ID: a new ID stalls, a bound one still goes.
    step(1, 0, 0, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
    for (int i = 0; i < NR; i++) begin
      step(0, 1, i, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
      chk($sformatf("bind_uid%0d", i), a_uid, i * NC);
    end
    chk("bind_rows", a_rows, NR);
    step(0, 1, 20, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
    chk("bind_new_ready", a_ready, 0);
    step(0, 1, 7, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
    chk("bind_match_ready", a_ready, 1);
    chk("bind_match_uid", a_uid, 'h71);

    // Same-cycle grant and free on one row, then a free on an empty row.
    step(1, 0, 0, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
    step(0, 1, 0, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
    chk("gf_first_uid", a_uid, 'h00);
    step(0, 1, 0, 1, 'h00, a_ready, a_uid, a_rest, a_ferr, a_rows);
    chk("gf_uid", a_uid, 'h01);
    chk("gf_rows", a_rows, 1);
    chk("gf_free_err", a_ferr, 0);
    step(0, 0, 0, 1, 'h50, a_ready, a_uid, a_rest, a_ferr, a_rows);
    chk("empty_free_err", a_ferr, 1);
    chk("empty_rows", a_rows, 1);
    step(0, 0, 0, 0, 0, a_ready, a_uid, a_rest, a_ferr, a_rows);
    chk("empty_after_uid", a_uid, 'h02);
    chk("empty_after_ferr", a_ferr, 0);
    step(0, 0, 0, 1, 'h07, a_ready, a_uid, a_rest, a_ferr, a_rows);
    chk("gf_single_left", a_rows, 0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rr = ($urandom_range(0, 99) == 0);
      av = ($urandom_range(0, 9) < 7);
      fr = ($urandom_range(0, 9) < 4);
      row = int'($urandom_range(0, NR - 1));
      if ($urandom_range(0, 9) < 8) begin
        st = row;
        for (int j = 0; j < NR; j++) begin
          if (m_q[(st + j) % NR].size() > 0) begin
            row = (st + j) % NR;
            break;
          end
        end
      end
      col = int'($urandom_range(0, NC - 1));
      uu = make_uid(row, col);
      step(rr, av, int'($urandom_range(0, 19)), fr, int'(uu),
           a_ready, a_uid, a_rest, a_ferr, a_rows);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
